// File: rtl/plexers_pkg.sv
// Shared constants for the plexers group: demux mode selection and drop-counter limit.
package plexers_pkg;

   localparam int DEMUX_MODE_ADDR = 0;
   localparam int DEMUX_MODE_RR   = 1;
   localparam int DROP_CNT_MAX    = 255;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel: loads a word, holds it
// until the consumer takes it, and clears on drain unless reloaded in the same cycle.
module demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             ready,
   input  logic [WIDTH-1:0] loadData,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= 1'b0;
         // NOTE: the data register is reset as well so out_data reads zero after reset.
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= loadData;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: addressed or round-robin routing into
// per-channel one-entry slots, with bad-select dropping and a saturating drop counter.
module stream_demux
   import plexers_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int NUM_OUT = 8,
   parameter int SEL_W   = 3,
   parameter int MODE    = DEMUX_MODE_ADDR
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [SEL_W-1:0]         in_sel,
   output logic [NUM_OUT-1:0]       out_valid,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic [NUM_OUT*WIDTH-1:0] out_data,
   output logic                     drop_pulse,
   output logic [7:0]               drop_count
);

   logic [SEL_W-1:0]   rrPtr;
   logic [SEL_W-1:0]   target;
   logic               targetBad;
   logic               slotFree;
   logic               accept;
   logic [NUM_OUT-1:0] loadVec;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      target    = (MODE == DEMUX_MODE_RR) ? rrPtr : in_sel;
      targetBad = (MODE == DEMUX_MODE_ADDR) && (int'(in_sel) >= NUM_OUT);
      slotFree  = 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (int'(target) == k) slotFree = ~out_valid[k] | out_ready[k];
      end

      // Dropped words never wait on a slot; good words wait only on their own target.
      if (reset)          in_ready = 1'b0;
      else if (targetBad) in_ready = enable;
      else                in_ready = enable & slotFree;

      accept  = in_valid & in_ready;
      loadVec = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         loadVec[k] = accept & ~targetBad & (int'(target) == k);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rrPtr      <= '0;
         drop_pulse <= 1'b0;
         drop_count <= '0;
      end else begin
         drop_pulse <= accept & targetBad;
         if (accept && targetBad && (drop_count != 8'(DROP_CNT_MAX)))
            drop_count <= drop_count + 8'd1;
         if ((MODE == DEMUX_MODE_RR) && accept)
            rrPtr <= (int'(rrPtr) == NUM_OUT - 1) ? '0 : rrPtr + SEL_W'(1);
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : gSlot
      demux_slot #(.WIDTH(WIDTH)) slot (
         .clock    (clock),
         .reset    (reset),
         .load     (loadVec[k]),
         .ready    (out_ready[k]),
         .loadData (in_data),
         .valid    (out_valid[k]),
         .data     (out_data[k*WIDTH +: WIDTH])
      );
   end

endmodule
